// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the MEM-stage / frame-readout RAM arbiter.
// Also holds the opcodes the MEM stage decodes to form mem_req and mem_we.
package mem_arb_pkg;

  typedef enum logic {
    OWN_MEM     = 1'b0,
    OWN_READOUT = 1'b1
  } owner_e;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } frame_state_e;

  localparam int FRAME_PIXELS_DEF = 153600;
  localparam int RAM_W            = 32;

  // Opcodes: CP is a word read (mem_we=0), GP is a pixel write (mem_we=1).
  localparam logic [3:0] OP_CP = 4'd6;
  localparam logic [3:0] OP_GP = 4'd10;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Under contention the requester that did not
// win most recently is granted; last_owner starts at OWN_READOUT.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_mem,
  input  logic req_rd,
  output logic gnt_mem,
  output logic gnt_rd
);

  owner_e last_owner;

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    gnt_mem = 1'b0;
    gnt_rd  = 1'b0;
    if (req_mem && req_rd) begin
      if (last_owner == OWN_READOUT) gnt_mem = 1'b1;
      else                           gnt_rd  = 1'b1;
    end else begin
      gnt_mem = req_mem;
      gnt_rd  = req_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n)       last_owner <= OWN_READOUT;
    else if (gnt_mem) last_owner <= OWN_MEM;
    else if (gnt_rd)  last_owner <= OWN_READOUT;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data RAM between the MEM stage and the frame readout
// port, with a FILL/FULL frame FSM. Optional counters: define MEM_ARB_PERF_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                ADDR_W       = 20,
  parameter int                FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter logic [ADDR_W-1:0] FRAME_BASE   = ADDR_W'(32'h0004_0000),
  parameter int                PIX_W        = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            mem_req,
  input  logic                            mem_we,
  input  logic [ADDR_W-1:0]               mem_addr,
  input  logic [PIX_W-1:0]                mem_wdata,
  output logic                            mem_gnt,
  output logic                            mem_rvalid,
  output logic [RAM_W-1:0]                mem_rdata,
  output logic                            stall,
  input  logic                            rd_req,
  output logic                            rd_gnt,
  output logic                            rd_valid,
  output logic [PIX_W-1:0]                rd_data,
  output logic                            rd_last,
  output logic                            ram_en,
  output logic                            ram_we,
  output logic [ADDR_W-1:0]               ram_addr,
  output logic [RAM_W-1:0]                ram_wdata,
  input  logic [RAM_W-1:0]                ram_rdata,
  output logic                            frame_done,
  output logic [$clog2(FRAME_PIXELS)-1:0] pix_count
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]                     perf_stall_cyc,
  output logic [15:0]                     perf_frames
`endif
);

  localparam int              CNT_W = $clog2(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_PIXELS - 1);

  frame_state_e     state;
  logic [CNT_W-1:0] drain_ptr;
  logic             cp_pend;
  logic             dr_pend;
  logic             dr_last;
  logic [RAM_W-1:0] rdata_hold;

  logic mem_elig, rd_elig;
  logic gnt_m, gnt_r;
  logic gp_wr, cp_rd;
  logic fill_last, drain_last;

  // GP writes are only eligible while a frame is being filled.
  assign mem_elig = mem_req & (~mem_we | (state == FILL));
  assign rd_elig  = rd_req & (state == FULL);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_mem (mem_elig),
    .req_rd  (rd_elig),
    .gnt_mem (gnt_m),
    .gnt_rd  (gnt_r)
  );

  assign gp_wr      = gnt_m & mem_we;
  assign cp_rd      = gnt_m & ~mem_we;
  assign fill_last  = (pix_count == LAST);
  assign drain_last = (drain_ptr == LAST);

  assign mem_gnt    = gnt_m;
  assign rd_gnt     = gnt_r;
  assign stall      = mem_req & ~gnt_m;
  assign frame_done = (state == FULL);

  // Read data lands one cycle after the grant; pass it through on that cycle.
  assign mem_rvalid = cp_pend;
  assign mem_rdata  = cp_pend ? ram_rdata : rdata_hold;
  assign rd_valid   = dr_pend;
  assign rd_data    = dr_pend ? ram_rdata[PIX_W-1:0] : '0;
  assign rd_last    = dr_last;

  always_comb begin
    ram_en    = gnt_m | gnt_r;
    ram_we    = gp_wr;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt_r) begin
      ram_addr = FRAME_BASE + ADDR_W'(drain_ptr);
    end else if (gp_wr) begin
      ram_addr  = FRAME_BASE + ADDR_W'(pix_count);
      ram_wdata = RAM_W'(mem_wdata);
    end else if (cp_rd) begin
      ram_addr = mem_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      pix_count  <= '0;
      drain_ptr  <= '0;
      cp_pend    <= 1'b0;
      dr_pend    <= 1'b0;
      dr_last    <= 1'b0;
      rdata_hold <= '0;
    end else begin
      cp_pend <= cp_rd;
      dr_pend <= gnt_r;
      dr_last <= gnt_r & drain_last;
      if (cp_pend) rdata_hold <= ram_rdata;
      case (state)
        FILL: begin
          if (gp_wr) begin
            if (fill_last) begin
              pix_count <= '0;
              state     <= FULL;
            end else begin
              pix_count <= pix_count + CNT_W'(1);
            end
          end
        end
        FULL: begin
          if (gnt_r) begin
            if (drain_last) begin
              drain_ptr <= '0;
              state     <= FILL;
            end else begin
              drain_ptr <= drain_ptr + CNT_W'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cyc <= '0;
      perf_frames    <= '0;
    end else begin
      if (stall && (perf_stall_cyc != '1))
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (gnt_r && drain_last && (perf_frames != '1))
        perf_frames <= perf_frames + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 4-pixel frame and a behavioural RAM.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int          ADDR_W = 20;
  localparam int          PIX_W  = 8;
  localparam int          FP     = 4;
  localparam logic [19:0] FB     = 20'h40000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_wdata;
  logic              mem_gnt, mem_rvalid, stall;
  logic [31:0]       mem_rdata;
  logic              rd_req, rd_gnt, rd_valid, rd_last;
  logic [PIX_W-1:0]  rd_data;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = 32'h0;
  logic              frame_done;
  logic [1:0]        pix_count;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]       perf_stall_cyc;
  logic [15:0]       perf_frames;
`endif

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .FRAME_PIXELS (FP),
    .FRAME_BASE   (FB),
    .PIX_W        (PIX_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .rd_req     (rd_req),
    .rd_gnt     (rd_gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .frame_done (frame_done),
    .pix_count  (pix_count)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_frames    (perf_frames)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one cycle of read latency.
  logic [31:0] ram_mdl [bit [19:0]];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mdl[ram_addr] = ram_wdata;
      else        ram_rdata <= ram_mdl.exists(ram_addr) ? ram_mdl[ram_addr] : 32'hBAD0_0000;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_word(input logic [19:0] a);
    return ram_mdl.exists(a) ? ram_mdl[a] : 32'hBAD0_0000;
  endfunction

  logic [7:0] pix1 [4];
  logic [7:0] pix2 [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    pix1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    pix2 = '{8'h55, 8'h66, 8'h77, 8'h88};
    ram_mdl[20'h00010] = 32'hCAFE_F00D;
    rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; rd_req = 1'b0;

    // Reset state
    @(negedge clk); #1;
    check("rst_mem_gnt", 32'(mem_gnt), 0);
    check("rst_mem_rvalid", 32'(mem_rvalid), 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_last", 32'(rd_last), 0);
    check("rst_ram_en", 32'(ram_en), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_pix_count", 32'(pix_count), 0);
    rst_n = 1'b1;

    // Fill frame 1
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b1; mem_wdata = pix1[i]; #1;
      check("fill_gnt", 32'(mem_gnt), 1);
      check("fill_ram_we", 32'(ram_we), 1);
      check("fill_addr", 32'(ram_addr), 32'(FB + 20'(i)));
      check("fill_wdata", ram_wdata, 32'(pix1[i]));
      check("fill_pix_count", 32'(pix_count), 32'(i));
    end

    // FULL: GP write held, three stall cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_wdata = 8'h55; #1;
      if (i == 0) begin
        check("full_frame_done", 32'(frame_done), 1);
        check("full_pix_count", 32'(pix_count), 0);
      end
      check("full_stall", 32'(stall), 1);
      check("full_no_gnt", 32'(mem_gnt), 0);
      check("full_ram_en", 32'(ram_en), 0);
    end
    for (int i = 0; i < 4; i++)
      check("ram_word", mdl_word(FB + 20'(i)), 32'(pix1[i]));

    // Drain frame 1 with rd_req held; GP write still pending
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rd_req = 1'b1; #1;
      check("drain_rd_valid", 32'(rd_valid), (k == 0) ? 0 : 1);
      if (k > 0) check("drain_rd_data", 32'(rd_data), 32'(pix1[k-1]));
      check("drain_rd_last", 32'(rd_last), (k == 4) ? 1 : 0);
      check("drain_frame_done", 32'(frame_done), (k == 4) ? 0 : 1);
      if (k < 4) begin
        check("drain_rd_gnt", 32'(rd_gnt), 1);
        check("drain_addr", 32'(ram_addr), 32'(FB + 20'(k)));
        check("drain_stall", 32'(stall), 1);
      end else begin
        check("last_rd_gnt", 32'(rd_gnt), 0);
        check("last_gp_gnt", 32'(mem_gnt), 1);
        check("last_gp_addr", 32'(ram_addr), 32'(FB));
        check("last_gp_wdata", ram_wdata, 32'h55);
      end
    end
    @(negedge clk);
    rd_req = 1'b0; mem_req = 1'b0; #1;
    check("after_pix_count", 32'(pix_count), 1);
    check("after_rd_valid", 32'(rd_valid), 0);
    check("after_ram_55", mdl_word(FB), 32'h55);

    // Fill rest of frame 2
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      mem_req = 1'b1; mem_we = 1'b1; mem_wdata = pix2[j]; #1;
      check("fill2_gnt", 32'(mem_gnt), 1);
      check("fill2_addr", 32'(ram_addr), 32'(FB + 20'(j)));
    end

    // One uncontested drain grant leaves last_owner = READOUT
    @(negedge clk);
    mem_req = 1'b0; rd_req = 1'b1; #1;
    check("f2_frame_done", 32'(frame_done), 1);
    check("f2_rd_gnt0", 32'(rd_gnt), 1);

    // CP read and readout contend: MEM wins
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 20'h00010; #1;
    check("rr_rd_data55", 32'(rd_data), 32'h55);
    check("rr_mem_gnt", 32'(mem_gnt), 1);
    check("rr_rd_gnt", 32'(rd_gnt), 0);
    check("rr_addr", 32'(ram_addr), 32'h10);
    check("rr_ram_we", 32'(ram_we), 0);

    @(negedge clk);
    mem_req = 1'b0; #1;
    check("cp_rvalid", 32'(mem_rvalid), 1);
    check("cp_rdata", mem_rdata, 32'hCAFE_F00D);
    check("rr_rd_gnt_next", 32'(rd_gnt), 1);
    check("rr_rd_addr_next", 32'(ram_addr), 32'(FB + 20'd1));

    @(negedge clk); #1;
    check("cp_rvalid_pulse", 32'(mem_rvalid), 0);
    check("cp_rdata_hold", mem_rdata, 32'hCAFE_F00D);
    check("f2_data66", 32'(rd_data), 32'h66);
    @(negedge clk); #1;
    check("f2_data77", 32'(rd_data), 32'h77);
    check("f2_last_early", 32'(rd_last), 0);
    @(negedge clk);
    rd_req = 1'b0; #1;
    check("f2_data88", 32'(rd_data), 32'h88);
    check("f2_last", 32'(rd_last), 1);
    check("f2_frame_done_clr", 32'(frame_done), 0);
`ifdef MEM_ARB_PERF_EN
    check("perf_stall", perf_stall_cyc, 7);
    check("perf_frames", 32'(perf_frames), 2);
`endif

    // Reset while a CP read is in flight
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_wdata = 8'h99; #1;
    check("pre_rst_gnt", 32'(mem_gnt), 1);
    @(negedge clk);
    mem_we = 1'b0; mem_addr = 20'h00010; #1;
    check("pre_rst_cp_gnt", 32'(mem_gnt), 1);
    check("pre_rst_pix_count", 32'(pix_count), 1);
    @(posedge clk); #2;
    rst_n = 1'b0; mem_req = 1'b0;
    @(negedge clk); #1;
    check("rst2_rvalid", 32'(mem_rvalid), 0);
    check("rst2_rdata", mem_rdata, 0);
    check("rst2_pix_count", 32'(pix_count), 0);
    check("rst2_frame_done", 32'(frame_done), 0);
    check("rst2_ram_en", 32'(ram_en), 0);
`ifdef MEM_ARB_PERF_EN
    check("rst2_perf_stall", perf_stall_cyc, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rst2_rvalid_after", 32'(mem_rvalid), 0);
    check("rst2_rd_valid_after", 32'(rd_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
